// File: rtl/pe_scatter.sv
`default_nettype none
// ============================================================================
// Module      : pe_scatter
// Description : Serial-to-lane deserializer for the PE array. Signed words
//               arriving one per cycle are collected into a shadow bank.
//               When a group closes, the bank is copied into a held output
//               vector together with a per-lane enable mask and a lane count.
//               The shadow bank refills while the previous vector is still
//               held at the output, so consecutive groups overlap.
//
// Ports       : rst           async active-high reset
//               clk           rising-edge clock
//               enable        input-side run enable (also gates transfers)
//               cfg_n_active  lanes per group; 0 or >N_PE selects N_PE
//               in_valid/in_ready/in_data/in_last   input word stream
//               out_valid/out_ready                 output vector handshake
//               out_data      N_PE signed lanes, unused lanes read 0
//               lane_enable   bit i set when lane i holds a real word
//               out_count     number of real lanes in out_data
//
// Revision    : 1.0  initial release
// ============================================================================
module pe_scatter #(
    parameter int N_PE        = 32,
    parameter int WID_PE_BITS = 16,
    parameter int CNT_W       = $clog2(N_PE + 1)
) (
    input  logic                          rst,
    input  logic                          clk,
    input  logic                          enable,
    input  logic [CNT_W-1:0]              cfg_n_active,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic signed [WID_PE_BITS-1:0] in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [WID_PE_BITS-1:0] out_data [N_PE-1:0],
    output logic [N_PE-1:0]               lane_enable,
    output logic [CNT_W-1:0]              out_count
);

    localparam int              IDX_W   = $clog2(N_PE);
    localparam logic [CNT_W-1:0] c_N_PE = CNT_W'(N_PE);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t                        r_state;
    state_t                        w_state_nxt;

    logic [CNT_W-1:0]              r_wr_idx;
    logic [CNT_W-1:0]              r_limit;
    logic [N_PE-1:0]               r_mask;
    logic signed [WID_PE_BITS-1:0] r_shadow [N_PE];

    logic [CNT_W-1:0]              w_cfg_eff;
    logic [CNT_W-1:0]              w_limit;
    logic [CNT_W:0]                w_idx_inc;
    logic [IDX_W-1:0]              w_wr_ptr;
    logic                          w_accept;
    logic                          w_close;
    logic                          w_xfer;

    // Out-of-range or zero configuration means a full-width group.
    assign w_cfg_eff = ((cfg_n_active == '0) || (cfg_n_active > c_N_PE)) ? c_N_PE : cfg_n_active;

    // The limit is sampled on the first word of a group; later words use the
    // latched copy so mid-group config changes cannot shorten the group.
    assign w_limit   = (r_wr_idx == '0) ? w_cfg_eff : r_limit;
    assign w_idx_inc = {1'b0, r_wr_idx} + {{CNT_W{1'b0}}, 1'b1};

    // In FILL the write index never exceeds N_PE-1, so the low bits address
    // the bank directly.
    assign w_wr_ptr  = r_wr_idx[IDX_W-1:0];

    // ------------------------------------------------------------------
    // Fill-side FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        w_accept    = 1'b0;
        w_close     = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            S_FILL: begin
                in_ready = enable && !rst;
                w_accept = in_valid && enable && !rst;
                // in_last and reaching the limit on the same word is a
                // single close.
                w_close  = w_accept && (in_last || (w_idx_inc == {1'b0, w_limit}));
                if (w_close) begin
                    w_state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                w_xfer = enable && (!out_valid || out_ready);
                if (w_xfer) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: begin
                w_state_nxt = S_FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow bank data (qualified by r_mask, so it needs no reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_shadow[w_wr_ptr] <= in_data;
        end
    end

    // ------------------------------------------------------------------
    // Fill bookkeeping
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_idx <= '0;
            r_limit  <= '0;
            r_mask   <= '0;
        end else if (w_xfer) begin
            r_wr_idx <= '0;
            r_mask   <= '0;
        end else if (w_accept) begin
            r_wr_idx         <= w_idx_inc[CNT_W-1:0];
            r_limit          <= w_limit;
            r_mask[w_wr_ptr] <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output vector. A transfer has priority over a plain drain so that a
    // handshake coinciding with a transfer keeps out_valid high.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid   <= 1'b0;
            lane_enable <= '0;
            out_count   <= '0;
            for (int i = 0; i < N_PE; i++) begin
                out_data[i] <= '0;
            end
        end else if (w_xfer) begin
            out_valid   <= 1'b1;
            lane_enable <= r_mask;
            // In HOLD the write index equals the number of accepted words.
            out_count   <= r_wr_idx;
            for (int i = 0; i < N_PE; i++) begin
                // Lanes not written this group are zeroed, never stale.
                out_data[i] <= r_mask[i] ? r_shadow[i] : '0;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_scatter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_scatter
// Description : Self-checking bench for pe_scatter. Expected vectors are
//               queued when a group is driven and compared when the DUT
//               hands a vector over (out_valid && out_ready).
// Revision    : 1.0  initial release
// ============================================================================
module tb_pe_scatter;

    localparam int N_PE = 32;
    localparam int W    = 16;
    localparam int CW   = 6;

    logic                clk = 1'b0;
    logic                rst;
    logic                enable;
    logic [CW-1:0]       cfg_n_active;
    logic                in_valid;
    logic                in_ready;
    logic signed [W-1:0] in_data;
    logic                in_last;
    logic                out_valid;
    logic                out_ready;
    logic signed [W-1:0] out_data [N_PE-1:0];
    logic [N_PE-1:0]     lane_enable;
    logic [CW-1:0]       out_count;

    typedef struct {
        logic signed [W-1:0] d [N_PE];
        logic [N_PE-1:0]     m;
        logic [CW-1:0]       c;
    } vec_t;

    vec_t                sb[$];
    logic signed [W-1:0] grp [N_PE];
    int                  checks = 0;
    int                  errors = 0;
    int                  cyc    = 0;

    pe_scatter #(
        .N_PE        (N_PE),
        .WID_PE_BITS (W),
        .CNT_W       (CW)
    ) u_dut (
        .rst          (rst),
        .clk          (clk),
        .enable       (enable),
        .cfg_n_active (cfg_n_active),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .lane_enable  (lane_enable),
        .out_count    (out_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: every handshake consumes the oldest expected vector.
    always @(negedge clk) begin
        vec_t e;
        int   bad;
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got vector with count %0d, required no vector", out_count);
            end else begin
                e = sb.pop_front();
                checks++;
                if (out_count !== e.c) begin
                    errors++;
                    $display("FAIL sb_count: got %0d, required %0d", out_count, e.c);
                end
                checks++;
                if (lane_enable !== e.m) begin
                    errors++;
                    $display("FAIL sb_mask: got %h, required %h", lane_enable, e.m);
                end
                bad = -1;
                for (int i = 0; i < N_PE; i++) begin
                    if (out_data[i] !== e.d[i] && bad < 0) bad = i;
                end
                checks++;
                if (bad >= 0) begin
                    errors++;
                    $display("FAIL sb_data lane %0d: got %0d, required %0d", bad, out_data[bad], e.d[bad]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int n);
        vec_t e;
        for (int i = 0; i < N_PE; i++) begin
            e.d[i] = (i < n) ? grp[i] : '0;
            e.m[i] = (i < n);
        end
        e.c = CW'(n);
        sb.push_back(e);
    endtask

    task automatic send_word(input logic signed [W-1:0] d, input logic last);
        bit ok;
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        ok       = 1'b0;
        n        = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word %0d not accepted, required accept within 100 cycles", d);
        end
    endtask

    task automatic run_group(input int n, input bit use_last, input bit push, input int cfg_after_first);
        if (push) push_exp(n);
        for (int i = 0; i < n; i++) begin
            send_word(grp[i], use_last && (i == n - 1));
            if (i == 0 && cfg_after_first >= 0) cfg_n_active = CW'(cfg_after_first);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || out_valid) && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL drain_timeout: %0d vectors pending, required 0", sb.size());
        end
    endtask

    task automatic test_reset();
        int bad;
        rst = 1'b1; enable = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; cfg_n_active = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b, required 0", out_valid); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, required 0", in_ready); end
        checks++;
        if (lane_enable !== '0) begin errors++; $display("FAIL rst_lane_enable: got %h, required 0", lane_enable); end
        checks++;
        if (out_count !== '0) begin errors++; $display("FAIL rst_out_count: got %0d, required 0", out_count); end
        bad = -1;
        for (int i = 0; i < N_PE; i++) if (out_data[i] !== '0 && bad < 0) bad = i;
        checks++;
        if (bad >= 0) begin errors++; $display("FAIL rst_out_data lane %0d: got %0d, required 0", bad, out_data[bad]); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL post_rst_in_ready: got %b, required 1", in_ready); end
        enable = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL post_rst_in_ready_en0: got %b, required 0", in_ready); end
        enable = 1'b1;
        tick();
    endtask

    task automatic test_full_group();
        cfg_n_active = '0;
        out_ready    = 1'b1;
        for (int i = 0; i < N_PE; i++) grp[i] = W'(i + 1);
        run_group(32, 1'b0, 1'b1, -1);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL full_latency_early: out_valid got %b, required 0", out_valid); end
        tick();
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL full_latency: out_valid got %b, required 1", out_valid); end
        wait_drain();
    endtask

    task automatic test_short();
        cfg_n_active = CW'(32);
        grp[0] = -16'sd3; grp[1] = -16'sd2; grp[2] = -16'sd1; grp[3] = 16'sd0; grp[4] = 16'sd7;
        run_group(5, 1'b1, 1'b1, -1);
        wait_drain();
    endtask

    task automatic test_single();
        cfg_n_active = CW'(1);
        grp[0] = -16'sd32768;
        run_group(1, 1'b0, 1'b1, -1);
        cfg_n_active = '0;
        grp[0] = 16'sh1234;
        run_group(1, 1'b1, 1'b1, -1);
        // in_last coinciding with the limit must close only once.
        cfg_n_active = CW'(3);
        for (int i = 0; i < 3; i++) grp[i] = W'(500 + i);
        run_group(3, 1'b1, 1'b1, -1);
        cfg_n_active = CW'(2);
        for (int i = 0; i < 2; i++) grp[i] = W'(600 + i);
        run_group(2, 1'b0, 1'b1, -1);
        wait_drain();
    endtask

    task automatic test_backpressure();
        int bad;
        out_ready    = 1'b0;
        cfg_n_active = CW'(8);
        for (int i = 0; i < 8; i++) grp[i] = W'(10 + i);
        run_group(8, 1'b0, 1'b1, -1);
        for (int i = 0; i < 8; i++) grp[i] = W'(-100 - i);
        run_group(8, 1'b0, 1'b1, -1);
        tick();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b, required 0", in_ready); end
            checks++;
            if (out_valid !== 1'b1 || out_count !== sb[0].c || lane_enable !== sb[0].m) begin
                errors++;
                $display("FAIL bp_hold: valid %b count %0d mask %h, required 1 %0d %h",
                         out_valid, out_count, lane_enable, sb[0].c, sb[0].m);
            end
            bad = -1;
            for (int i = 0; i < N_PE; i++) if (out_data[i] !== sb[0].d[i] && bad < 0) bad = i;
            checks++;
            if (bad >= 0) begin errors++; $display("FAIL bp_hold_data lane %0d: got %0d, required %0d", bad, out_data[bad], sb[0].d[bad]); end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_data[0] !== sb[0].d[0] || out_count !== 6'd8) begin
            errors++;
            $display("FAIL bp_swap: valid %b lane0 %0d count %0d, required 1 %0d 8",
                     out_valid, out_data[0], out_count, sb[0].d[0]);
        end
        out_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_cfg_latch();
        out_ready    = 1'b1;
        cfg_n_active = CW'(4);
        for (int i = 0; i < 4; i++) grp[i] = W'(40 + i);
        run_group(4, 1'b0, 1'b1, 2);
        for (int i = 0; i < 2; i++) grp[i] = W'(50 + i);
        run_group(2, 1'b0, 1'b1, -1);
        wait_drain();
    endtask

    task automatic test_enable();
        out_ready    = 1'b0;
        cfg_n_active = CW'(3);
        for (int i = 0; i < 3; i++) grp[i] = W'(60 + i);
        run_group(3, 1'b0, 1'b1, -1);
        cfg_n_active = CW'(6);
        for (int i = 0; i < 6; i++) grp[i] = W'(70 + i);
        push_exp(6);
        send_word(grp[0], 1'b0);
        send_word(grp[1], 1'b0);
        enable   = 1'b0;
        in_valid = 1'b1;
        in_data  = grp[2];
        for (int k = 0; k < 3; k++) begin
            if (k == 0) out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL en_in_ready: got %b, required 0", in_ready); end
            tick();
            if (k == 0) out_ready = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin errors++; $display("FAIL en_drain: out_valid got %b, required 0", out_valid); end
        end
        enable = 1'b1;
        for (int i = 2; i < 6; i++) send_word(grp[i], 1'b0);
        out_ready = 1'b1;
        wait_drain();
    endtask

    task automatic test_reset_mid();
        out_ready    = 1'b0;
        cfg_n_active = '0;
        grp[0] = 16'sd5;
        run_group(1, 1'b1, 1'b0, -1);
        for (int i = 0; i < 10; i++) send_word(W'(i * 7 - 50), 1'b0);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %b, required 1", out_valid); end
        #3;
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || lane_enable !== '0 || out_count !== '0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL rm_async: valid %b mask %h count %0d ready %b, required 0 0 0 0",
                     out_valid, lane_enable, out_count, in_ready);
        end
        #1;
        rst = 1'b0;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < N_PE; i++) grp[i] = W'(300 + i);
        run_group(32, 1'b0, 1'b1, -1);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        int c0;
        int c1;
        cfg_n_active = '0;
        out_ready    = 1'b1;
        for (int i = 0; i < N_PE; i++) grp[i] = W'(1000 + i);
        push_exp(32);
        send_word(grp[0], 1'b0);
        c0 = cyc;
        for (int i = 1; i < N_PE; i++) send_word(grp[i], 1'b0);
        for (int i = 0; i < N_PE; i++) grp[i] = W'(2000 + i);
        push_exp(32);
        for (int i = 0; i < N_PE; i++) send_word(grp[i], 1'b0);
        c1 = cyc;
        checks++;
        if (c1 - c0 !== 64) begin errors++; $display("FAIL b2b_cycles: got %0d, required 64", c1 - c0); end
        wait_drain();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_full_group();
        test_short();
        test_single();
        test_backpressure();
        test_cfg_latch();
        test_enable();
        test_reset_mid();
        test_back_to_back();
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
